// File: rtl/partition_write_gen.sv
// rtl/partition_write_gen.sv - writes a result stream into a rectangular window of a row-major output array
// One word per handshake; done pulses with the final RAM write so the controller can launch the next partition.
module partition_write_gen #(
    parameter int PARTITION_WIDTH  = 3,
    parameter int PARTITION_HEIGHT = 3,
    parameter int ARRAY_WIDTH      = 8,
    parameter int ADDRESS_WIDTH    = 16,
    parameter int DATA_WIDTH       = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_base_address,
    input  logic                     i_in_valid,
    input  logic [DATA_WIDTH-1:0]    i_in_data,
    output logic                     o_in_ready,
    output logic                     o_wr_en,
    output logic [ADDRESS_WIDTH-1:0] o_wr_address,
    output logic [DATA_WIDTH-1:0]    o_wr_data,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int COL_W = (PARTITION_WIDTH > 1) ? $clog2(PARTITION_WIDTH) : 1;
    localparam int ROW_W = (PARTITION_HEIGHT > 1) ? $clog2(PARTITION_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PARTITION_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PARTITION_HEIGHT - 1);
    // Jump from the last column of one window row to the first column of the next.
    localparam logic [ADDRESS_WIDTH-1:0] ROW_STEP = ADDRESS_WIDTH'(ARRAY_WIDTH - PARTITION_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_ptr;
    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;
    logic                     r_in_ready;
    logic                     r_wr_en;
    logic [ADDRESS_WIDTH-1:0] r_wr_address;
    logic [DATA_WIDTH-1:0]    r_wr_data;
    logic                     r_busy;
    logic                     r_done;

    logic w_accept;
    logic w_col_end;
    logic w_last;

    assign w_accept  = i_in_valid && r_in_ready;
    assign w_col_end = (r_col == COL_LAST);
    assign w_last    = w_col_end && (r_row == ROW_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ptr      <= i_base_address;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        r_wr_en      <= 1'b1;
                        r_wr_address <= r_ptr;
                        r_wr_data    <= i_in_data;
                        if (w_last) begin
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_FINISH;
                        end else if (!w_col_end) begin
                            r_col <= r_col + 1'b1;
                            r_ptr <= r_ptr + 1'b1;
                        end else begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                            r_ptr <= r_ptr + ROW_STEP;
                        end
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_wr_en      = r_wr_en;
    assign o_wr_address = r_wr_address;
    assign o_wr_data    = r_wr_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
